// File: rtl/boot_loader.sv
// Host-driven boot loader: synchronizes an async nibble strobe and programs memory word by word.
// Optional checksum stage is compiled in with `define BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            prog_req_i,
  input  logic                            nib_strobe_i,
  input  logic [REGISTER_WIDTH-1:0]       nib_i,
  output logic                            bl_programm_o,
  output logic [REGISTER_WIDTH-1:0]       bl_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic                            bl_write_en_mem_o,
  output logic                            done_o,
  output logic                            error_o
);

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic req_meta_reg, req_sync_reg;
  logic strb_meta_reg, strb_sync_reg, strb_prev_reg;
  logic strb_edge;

  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_reg, addr_next;
  logic [REGISTER_WIDTH-1:0]       data_reg, data_next;
  logic                            done_reg, done_next;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [REGISTER_WIDTH-1:0] sum_reg, sum_next;
  logic                      error_reg, error_next;
`endif

  // Host signals are asynchronous: two flops each, plus one history flop for strobe edges.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_meta_reg  <= 1'b0;
      req_sync_reg  <= 1'b0;
      strb_meta_reg <= 1'b0;
      strb_sync_reg <= 1'b0;
      strb_prev_reg <= 1'b0;
    end else begin
      req_meta_reg  <= prog_req_i;
      req_sync_reg  <= req_meta_reg;
      strb_meta_reg <= nib_strobe_i;
      strb_sync_reg <= strb_meta_reg;
      strb_prev_reg <= strb_sync_reg;
    end
  end

  assign strb_edge = strb_sync_reg & ~strb_prev_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_reg   <= '0;
      error_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_reg   <= sum_next;
      error_reg <= error_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    done_next  = done_reg;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_next   = sum_reg;
    error_next = error_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_sync_reg) begin
          state_next = LOAD;
          addr_next  = '0;
          done_next  = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
          sum_next   = '0;
          error_next = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (!req_sync_reg) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (strb_edge) begin
          data_next  = nib_i;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // The write pulse is decoded from this state, so it is already out even on abort.
        addr_next = addr_reg + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_next  = sum_reg + data_reg;
`endif
        if (!req_sync_reg) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (addr_reg == LAST_ADDR) begin
          addr_next = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
          done_next  = 1'b1;
`endif
        end else begin
          state_next = LOAD;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHECK: begin
        if (!req_sync_reg) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (strb_edge) begin
          error_next = (nib_i != sum_reg);
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        if (!req_sync_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bl_programm_o     = (state_reg != IDLE);
  assign bl_write_en_mem_o = (state_reg == WRITE);
  assign bl_address_o      = addr_reg;
  assign bl_data_o         = data_reg;
  assign done_o            = done_reg;
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign error_o           = error_reg;
`else
  assign error_o           = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; a negedge monitor logs every write pulse.
// Checksum scenarios run only when BOOT_LOADER_CHECKSUM_EN is defined.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       prog_req_i;
  logic       nib_strobe_i;
  logic [3:0] nib_i;
  logic       bl_programm_o;
  logic [3:0] bl_data_o;
  logic [3:0] bl_address_o;
  logic       bl_write_en_mem_o;
  logic       done_o;
  logic       error_o;

  int checks = 0;
  int errors = 0;

  int         wr_cnt = 0;
  int         cur_width = 0;
  int         max_width = 0;
  logic [3:0] wr_addr [256];
  logic [3:0] wr_data [256];

  always #5 clk = ~clk;

  boot_loader #(
    .REGISTER_WIDTH(4),
    .MEMORY_ADDRESS_WIDTH(4),
    .MEMORY_REGISTERS(16)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .prog_req_i(prog_req_i),
    .nib_strobe_i(nib_strobe_i),
    .nib_i(nib_i),
    .bl_programm_o(bl_programm_o),
    .bl_data_o(bl_data_o),
    .bl_address_o(bl_address_o),
    .bl_write_en_mem_o(bl_write_en_mem_o),
    .done_o(done_o),
    .error_o(error_o)
  );

  always @(negedge clk) begin
    if (bl_write_en_mem_o === 1'b1) begin
      if (wr_cnt < 256) begin
        wr_addr[wr_cnt] = bl_address_o;
        wr_data[wr_cnt] = bl_data_o;
      end
      $display("write #%0d addr=%0d data=0x%h", wr_cnt, bl_address_o, bl_data_o);
      wr_cnt++;
      cur_width++;
      if (cur_width > max_width) max_width = cur_width;
    end else begin
      cur_width = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] v, input int hi, input int lo);
    nib_i = v;
    nib_strobe_i = 1'b1;
    cycles(hi);
    nib_strobe_i = 1'b0;
    cycles(lo);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    prog_req_i = 1'b0;
    nib_strobe_i = 1'b0;
    cycles(2);
    reset_i = 1'b0;
    cycles(1);
  endtask

  task automatic start_session();
    prog_req_i = 1'b1;
    cycles(3);
  endtask

  task automatic check_writes(input string name, input int base, input int n,
                              input logic [3:0] fixed_data, input bit data_is_addr);
    logic [3:0] exp_d;
    for (int i = 0; i < n; i++) begin
      exp_d = data_is_addr ? 4'(i) : fixed_data;
      checks++;
      if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== exp_d) begin
        errors++;
        $display("FAIL %s write %0d: got addr=%0d data=0x%h, expected addr=%0d data=0x%h",
                 name, i, wr_addr[base+i], wr_data[base+i], i, exp_d);
      end
    end
  endtask

  task automatic test_reset();
    nib_i = 4'h0;
    reset_i = 1'b1;
    prog_req_i = 1'b0;
    nib_strobe_i = 1'b0;
    cycles(3);
    checks++;
    if ({bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, error_o} !== 12'h0) begin
      errors++;
      $display("FAIL reset outputs: got prog=%b data=%h addr=%h we=%b done=%b err=%b, expected all 0",
               bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, error_o);
    end
    reset_i = 1'b0;
    cycles(1);
    $display("test_reset done");
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    start_session();
    nib_i = 4'h5;
    nib_strobe_i = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bl_write_en_mem_o === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 3 || n > 4) begin
      errors++;
      $display("FAIL latency: got %0d clocks, expected 3 or 4", n);
    end
    cycles(2);
    nib_strobe_i = 1'b0;
    cycles(3);
    $display("test_latency: %0d clocks", n);
  endtask

  task automatic test_full_load();
    int base;
    do_reset();
    start_session();
    base = wr_cnt;
    for (int i = 0; i < 16; i++) strobe(4'(i), 3, 3);
`ifdef BOOT_LOADER_CHECKSUM_EN
    strobe(4'h8, 3, 3);
`endif
    cycles(2);
    checks++;
    if (wr_cnt - base !== 16) begin
      errors++;
      $display("FAIL full_load count: got %0d writes, expected 16", wr_cnt - base);
    end
    check_writes("full_load", base, 16, 4'h0, 1'b1);
    checks++;
    if (done_o !== 1'b1 || bl_programm_o !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL full_load status: got done=%b prog=%b err=%b, expected 1 1 0",
               done_o, bl_programm_o, error_o);
    end
    $display("test_full_load done");
  endtask

  // Continues from the DONE state left by test_full_load.
  task automatic test_release();
    int n;
    int base;
    prog_req_i = 1'b0;
    n = 99;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (bl_programm_o === 1'b0) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n > 3) begin
      errors++;
      $display("FAIL release latency: got %0d cycles, expected <= 3", n);
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL release done: got %b, expected 1", done_o);
    end
    @(negedge clk);
    start_session();
    checks++;
    if (done_o !== 1'b0 || bl_programm_o !== 1'b1) begin
      errors++;
      $display("FAIL restart status: got done=%b prog=%b, expected 0 1", done_o, bl_programm_o);
    end
    base = wr_cnt;
    strobe(4'h3, 3, 3);
    checks++;
    if (wr_cnt - base !== 1 || wr_addr[base] !== 4'h0 || wr_data[base] !== 4'h3) begin
      errors++;
      $display("FAIL restart write: got count=%0d addr=%0d data=0x%h, expected 1 0 0x3",
               wr_cnt - base, wr_addr[base], wr_data[base]);
    end
    prog_req_i = 1'b0;
    cycles(4);
    $display("test_release: programm dropped after %0d cycles", n);
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [3:0] csum, input logic exp_err);
    int base;
    do_reset();
    start_session();
    base = wr_cnt;
    for (int i = 0; i < 16; i++) strobe(4'h1, 3, 3);
    strobe(csum, 3, 3);
    cycles(2);
    checks++;
    if (wr_cnt - base !== 16) begin
      errors++;
      $display("FAIL checksum count: got %0d writes, expected 16", wr_cnt - base);
    end
    checks++;
    if (done_o !== 1'b1 || error_o !== exp_err) begin
      errors++;
      $display("FAIL checksum 0x%h: got done=%b err=%b, expected 1 %b", csum, done_o, error_o, exp_err);
    end
    $display("test_checksum 0x%h: err=%b", csum, error_o);
  endtask
`endif

  task automatic test_abort();
    int base;
    do_reset();
    start_session();
    base = wr_cnt;
    for (int i = 0; i < 5; i++) strobe(4'(i), 3, 3);
    prog_req_i = 1'b0;
    cycles(5);
    checks++;
    if (wr_cnt - base !== 5) begin
      errors++;
      $display("FAIL abort count: got %0d writes, expected 5", wr_cnt - base);
    end
    check_writes("abort", base, 5, 4'h0, 1'b1);
    checks++;
    if (bl_programm_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort status: got prog=%b done=%b, expected 0 0", bl_programm_o, done_o);
    end
    $display("test_abort done");
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    start_session();
    base = wr_cnt;
    for (int i = 0; i < 7; i++) strobe(4'(i + 8), 3, 3);
    reset_i = 1'b1;
    prog_req_i = 1'b0;
    cycles(1);
    reset_i = 1'b0;
    checks++;
    if ({bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, error_o} !== 12'h0) begin
      errors++;
      $display("FAIL mid_reset outputs: got prog=%b data=%h addr=%h we=%b done=%b err=%b, expected all 0",
               bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, error_o);
    end
    strobe(4'h2, 2, 2);
    cycles(6);
    checks++;
    if (wr_cnt - base !== 7) begin
      errors++;
      $display("FAIL mid_reset writes: got %0d, expected 7", wr_cnt - base);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    start_session();
    base = wr_cnt;
    for (int i = 0; i < 16; i++) strobe(4'hA, 1, 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
    strobe(4'h0, 1, 1);
`endif
    cycles(4);
    checks++;
    if (wr_cnt - base !== 16) begin
      errors++;
      $display("FAIL back_to_back count: got %0d writes, expected 16", wr_cnt - base);
    end
    check_writes("back_to_back", base, 16, 4'hA, 1'b0);
    checks++;
    if (max_width !== 1) begin
      errors++;
      $display("FAIL pulse width: got %0d cycles, expected 1", max_width);
    end
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back status: got done=%b err=%b, expected 1 0", done_o, error_o);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_idle_strobes();
    int base;
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 4; i++) strobe(4'(i), 2, 2);
    cycles(3);
    checks++;
    if (wr_cnt - base !== 0 || bl_programm_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobes: got writes=%0d prog=%b, expected 0 0", wr_cnt - base, bl_programm_o);
    end
    $display("test_idle_strobes done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_load();
    test_release();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum(4'h0, 1'b0);
    test_checksum(4'h5, 1'b1);
`endif
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_idle_strobes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
